// File: rtl/doc_export_ctrl.sv
// doc_export_ctrl
// Owns the document RAM's single read/write port. The text editor always
// wins the port when it writes; otherwise, during an export, the controller
// reads each visible cell row by row and streams the characters to a UART
// transmitter over a valid/ready handshake, with an optional 8'h0A after
// every row.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, abort          export request (ignored while busy), synchronous cancel
//   editor_a/d/we         editor address {row[3:0], col[4:0]}, data, write enable
//   doc_a/d/we            document port (combinational arbitration)
//   doc_spo               document read data (asynchronous read)
//   tx_data/valid/ready   byte stream to the UART
//   busy                  export in progress (high in every state but IDLE)
//   done                  one-cycle pulse when an export completes
module doc_export_ctrl #(
    parameter int unsigned ROWS         = 15,
    parameter int unsigned COLS         = 20,
    parameter bit          EMIT_NEWLINE = 1'b1,
    parameter logic [7:0]  BLANK_CHAR   = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [8:0] editor_a,
    input  logic [7:0] editor_d,
    input  logic       editor_we,
    output logic [8:0] doc_a,
    output logic [7:0] doc_d,
    output logic       doc_we,
    input  logic [7:0] doc_spo,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_SEND    = 3'd2,
        ST_NEWLINE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam logic [4:0] COL_LAST = 5'(COLS - 1);
    localparam logic [7:0] NEWLINE_CHAR = 8'h0A;

    state_t     state_r;
    logic [3:0] row_r;
    logic [4:0] col_r;
    logic [7:0] tx_data_r;
    logic       tx_valid_r;
    logic       busy_r;
    logic       done_r;

    logic       hs_s;
    logic [8:0] doc_a_s;
    logic [7:0] doc_d_s;
    logic       doc_we_s;

    // Empty cells are stored as 8'h00 and exported as a printable blank.
    function automatic logic [7:0] blank_sub(input logic [7:0] b);
        return (b == 8'h00) ? BLANK_CHAR : b;
    endfunction

    assign hs_s = tx_valid_r & tx_ready;

    // Port arbitration: editor writes pass through unconditionally; the
    // export only drives the address while reading and the editor is idle.
    always_comb begin
        doc_d_s  = editor_d;
        doc_we_s = editor_we;
        doc_a_s  = editor_a;
        if ((state_r == ST_READ) && !editor_we) begin
            doc_a_s = {row_r, col_r};
        end else begin
            doc_a_s = editor_a;
        end
    end

    assign doc_a  = doc_a_s;
    assign doc_d  = doc_d_s;
    assign doc_we = doc_we_s;

    // Export sequencer with registered stream and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            row_r      <= 4'd0;
            col_r      <= 5'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (abort) begin
            // Cancel beats every transition, including a start in IDLE.
            state_r    <= ST_IDLE;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        row_r   <= 4'd0;
                        col_r   <= 5'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_READ;
                    end
                end
                ST_READ: begin
                    // An editor write owns the port this cycle, so the read
                    // data is not ours; retry next cycle.
                    if (!editor_we) begin
                        tx_data_r  <= blank_sub(doc_spo);
                        tx_valid_r <= 1'b1;
                        state_r    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (hs_s) begin
                        if (col_r < COL_LAST) begin
                            col_r      <= col_r + 5'd1;
                            tx_valid_r <= 1'b0;
                            state_r    <= ST_READ;
                        end else if (EMIT_NEWLINE) begin
                            col_r     <= 5'd0;
                            tx_data_r <= NEWLINE_CHAR;
                            state_r   <= ST_NEWLINE;
                        end else if (row_r < ROW_LAST) begin
                            col_r      <= 5'd0;
                            row_r      <= row_r + 4'd1;
                            tx_valid_r <= 1'b0;
                            state_r    <= ST_READ;
                        end else begin
                            tx_valid_r <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= ST_DONE;
                        end
                    end
                end
                ST_NEWLINE: begin
                    if (hs_s) begin
                        tx_valid_r <= 1'b0;
                        if (row_r == ROW_LAST) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            row_r   <= row_r + 4'd1;
                            state_r <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    // busy stays high through DONE and falls with the return to IDLE.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_doc_export_ctrl.sv
// Testbench for doc_export_ctrl: behavioural document RAM, scoreboard of
// expected bytes built from a shadow copy of the document contents, and a
// negedge monitor that pops the scoreboard on every accepted byte.
module tb_doc_export_ctrl;

    localparam int MODE_PLAIN = 0;
    localparam int MODE_RAND  = 1;
    localparam int MODE_EDIT  = 2;
    localparam int MODE_START = 3;
    localparam int MODE_ABORT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] editor_a = 9'h000;
    logic [7:0] editor_d = 8'h00;
    logic       editor_we = 1'b0;
    logic [8:0] doc_a;
    logic [7:0] doc_d;
    logic       doc_we;
    logic [7:0] doc_spo;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;
    int byte_cnt = 0;
    int done_cnt = 0;

    logic [7:0] mem     [0:511];
    logic [7:0] exp_mem [0:511];
    logic [7:0] rx      [0:511];
    logic [7:0] sb_q [$];

    doc_export_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .editor_a  (editor_a),
        .editor_d  (editor_d),
        .editor_we (editor_we),
        .doc_a     (doc_a),
        .doc_d     (doc_d),
        .doc_we    (doc_we),
        .doc_spo   (doc_spo),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Document RAM: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (doc_we) mem[doc_a] <= doc_d;
    end
    assign doc_spo = mem[doc_a];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard on each accepted byte, hold-stability of the stream.
    initial begin
        logic       hs;
        logic       prev_valid;
        logic       prev_hs;
        logic       prev_abort;
        logic       prev_rst;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_abort = 1'b0;
        prev_rst   = 1'b1;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            hs = tx_valid && tx_ready && !abort && !rst;
            if (prev_valid && !prev_hs && !prev_abort && !prev_rst && !rst) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (hs) begin
                check("sb_nonempty", {31'd0, (sb_q.size() > 0)}, 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_byte", {24'd0, tx_data}, {24'd0, e});
                end
                if (byte_cnt < 512) rx[byte_cnt] = tx_data;
                byte_cnt++;
            end
            if (done) done_cnt++;
            prev_valid = tx_valid;
            prev_hs    = hs;
            prev_abort = abort;
            prev_rst   = rst;
            prev_data  = tx_data;
        end
    end

    task automatic push_expected();
        logic [8:0] a;
        logic [7:0] b;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                a = {4'(r), 5'(c)};
                b = exp_mem[a];
                sb_q.push_back((b == 8'h00) ? 8'h20 : b);
            end
            sb_q.push_back(8'h0A);
        end
    endtask

    task automatic preload();
        logic [8:0] a;
        logic [7:0] d;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                a = {4'(r), 5'(c)};
                d = (a == 9'h000) ? 8'h41 : ((a == 9'h020) ? 8'h00 : 8'h42);
                @(posedge clk); #1;
                editor_we = 1'b1;
                editor_a  = a;
                editor_d  = d;
                exp_mem[a] = d;
            end
        end
        @(posedge clk); #1;
        editor_we = 1'b0;
    endtask

    // Leaves the bench #1 after the edge that samples start (edge 0).
    task automatic start_export();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_export(input int mode, input bit first_chk, output int done_edge);
        bit aborted;
        done_edge = -1;
        aborted   = 1'b0;
        byte_cnt  = 0;
        done_cnt  = 0;
        start_export();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("valid_low_edge0", {31'd0, tx_valid}, 32'd0);
        for (int n = 1; n <= 5000; n++) begin
            @(posedge clk); #1;
            if (first_chk && n == 1) begin
                check("first_valid", {31'd0, tx_valid}, 32'd1);
                check("first_byte", {24'd0, tx_data}, 32'h41);
            end
            if (done) begin
                done_edge = n;
                break;
            end
            if (mode == MODE_RAND) tx_ready = ($urandom_range(0, 2) == 0);
            if (mode == MODE_EDIT) begin
                if (n >= 10 && n <= 12) begin
                    editor_we = 1'b1;
                    editor_a  = 9'h005;
                    editor_d  = 8'h5A;
                    #1;
                    check("edit_doc_we", {31'd0, doc_we}, 32'd1);
                    check("edit_doc_a", {23'd0, doc_a}, 32'h005);
                end else begin
                    editor_we = 1'b0;
                end
            end
            if (mode == MODE_START) start = (n == 100);
            if (mode == MODE_ABORT) begin
                if (aborted) begin
                    abort = 1'b0;
                    check("abort_valid", {31'd0, tx_valid}, 32'd0);
                    check("abort_busy", {31'd0, busy}, 32'd0);
                    done_edge = n;
                    break;
                end else if (byte_cnt == 10) begin
                    abort   = 1'b1;
                    aborted = 1'b1;
                end
            end
        end
        tx_ready  = 1'b1;
        editor_we = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        check("no_timeout", {31'd0, (done_edge > 0)}, 32'd1);
    endtask

    task automatic finish_checks(input string tag);
        @(posedge clk); #1;
        check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        check({tag, "_bytes"}, byte_cnt, 32'd315);
        check({tag, "_done_cnt"}, done_cnt, 32'd1);
        check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    endtask

    initial begin
        int de;
        for (int i = 0; i < 512; i++) exp_mem[i] = 8'h00;

        // Reset state
        editor_a = 9'h1FF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_doc_a", {23'd0, doc_a}, 32'h1FF);
        rst = 1'b0;

        preload();

        // Plain export with tx_ready held high
        push_expected();
        run_export(MODE_PLAIN, 1'b1, de);
        check("t1_done_edge", de, 32'd615);
        finish_checks("t1");
        check("t1_byte21", {24'd0, rx[20]}, 32'h0A);
        check("t1_byte22", {24'd0, rx[21]}, 32'h20);

        // Back-pressure 1-in-3
        push_expected();
        run_export(MODE_RAND, 1'b1, de);
        finish_checks("t2");

        // start while busy is ignored
        push_expected();
        run_export(MODE_START, 1'b1, de);
        check("t5_done_edge", de, 32'd615);
        finish_checks("t5");

        // abort after byte 10, then restart from cell 0
        push_expected();
        run_export(MODE_ABORT, 1'b0, de);
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_done", done_cnt, 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_bytes", byte_cnt, 32'd10);
        sb_q.delete();
        push_expected();
        run_export(MODE_PLAIN, 1'b1, de);
        check("t4_restart_edge", de, 32'd615);
        finish_checks("t4r");

        // Editor write during READ of cell 5
        exp_mem[9'h005] = 8'h5A;
        push_expected();
        run_export(MODE_EDIT, 1'b0, de);
        check("t3_done_edge", de, 32'd618);
        finish_checks("t3");
        check("t3_byte5", {24'd0, rx[5]}, 32'h5A);

        // Asynchronous reset mid-SEND
        sb_q.delete();
        tx_ready = 1'b0;
        start_export();
        repeat (3) @(posedge clk);
        #1;
        check("t6_valid_pre", {31'd0, tx_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t6_tx_data", {24'd0, tx_data}, 32'h00);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        editor_we = 1'b1;
        editor_a  = 9'h123;
        editor_d  = 8'h77;
        #1;
        check("t6_doc_a_we", {23'd0, doc_a}, 32'h123);
        check("t6_doc_d", {24'd0, doc_d}, 32'h77);
        check("t6_doc_we", {31'd0, doc_we}, 32'd1);
        editor_we = 1'b0;
        editor_a  = 9'h0AB;
        #1;
        check("t6_doc_a_idle", {23'd0, doc_a}, 32'h0AB);
        check("t6_doc_we_idle", {31'd0, doc_we}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_idle_valid", {31'd0, tx_valid}, 32'd0);
        check("t6_idle_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
